// File: rtl/frontpanel_spi_sequencer.sv
// frontpanel_spi_sequencer
// Frames byte transactions to the front panel display MCU over the existing
// SPI host shifter. Register writes queue bytes in a local byte FIFO; a commit
// closes the group of uncommitted bytes into one transaction whose length is
// queued in a small length FIFO. A sequencer drops cs_n, waits the setup time,
// hands bytes one at a time to the shifter (shift_en/shift_done), waits the
// hold time, raises cs_n and then enforces a minimum inter-frame gap.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_data  push one byte into the byte FIFO
//   commit          close the current transaction (all bytes since last commit)
//   overflow_clr    clear the sticky overflow flag
//   shift_en        one-cycle start strobe to the SPI host shifter
//   shift_data      byte presented to the shifter, stable until shift_done
//   shift_done      one-cycle pulse from the shifter when a byte is out
//   cs_n            front panel chip select
//   busy            sequencer active or a committed transaction is queued
//   data_free       free byte FIFO slots
//   overflow        sticky: byte dropped (FIFO full) or commit lost (length FIFO full)
module frontpanel_spi_sequencer #(
  parameter int DATA_DEPTH = 64,
  parameter int LEN_DEPTH  = 4,
  parameter int CS_SETUP   = 16,
  parameter int CS_HOLD    = 16,
  parameter int CS_GAP     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          commit,
  input  logic                          overflow_clr,
  output logic                          shift_en,
  output logic [7:0]                    shift_data,
  input  logic                          shift_done,
  output logic                          cs_n,
  output logic                          busy,
  output logic [$clog2(DATA_DEPTH):0]   data_free,
  output logic                          overflow
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int LAW = $clog2(LEN_DEPTH);
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                           ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef logic [DAW:0]  len_t;   // byte counts and byte FIFO pointers
  typedef logic [LAW:0]  lptr_t;  // length FIFO pointers
  typedef logic [CW-1:0] tmr_t;

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT, HOLD, GAP} state_t;

  logic [7:0] data_mem [DATA_DEPTH];
  len_t       len_mem  [LEN_DEPTH];

  len_t   data_wr_ptr, data_rd_ptr;
  lptr_t  len_wr_ptr, len_rd_ptr;
  len_t   pending;
  len_t   remaining;
  tmr_t   timer;
  state_t state;

  logic data_full, len_full, len_empty;
  logic data_push;
  len_t commit_len;
  logic commit_ok, commit_err;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign data_full = (data_wr_ptr[DAW] != data_rd_ptr[DAW]) &&
                     (data_wr_ptr[DAW-1:0] == data_rd_ptr[DAW-1:0]);
  assign len_full  = (len_wr_ptr[LAW] != len_rd_ptr[LAW]) &&
                     (len_wr_ptr[LAW-1:0] == len_rd_ptr[LAW-1:0]);
  assign len_empty = (len_wr_ptr == len_rd_ptr);

  assign data_push  = wr_en && !data_full;
  // A byte written in the commit cycle belongs to the transaction being closed.
  assign commit_len = pending + len_t'(data_push);
  assign commit_ok  = commit && (commit_len != '0) && !len_full;
  assign commit_err = commit && (commit_len != '0) && len_full;

  assign data_free = len_t'(DATA_DEPTH) - (data_wr_ptr - data_rd_ptr);
  assign busy      = (state != IDLE) || !len_empty;

  // Write side: byte FIFO push, uncommitted count, length FIFO push, overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_wr_ptr <= '0;
      len_wr_ptr  <= '0;
      pending     <= '0;
      overflow    <= 1'b0;
    end else begin
      if (data_push)
        data_wr_ptr <= data_wr_ptr + len_t'(1);
      if (commit_ok) begin
        len_wr_ptr <= len_wr_ptr + lptr_t'(1);
        pending    <= '0;
      end else if (data_push) begin
        pending <= pending + len_t'(1);
      end
      // A new error in the same cycle as a clear leaves the flag set.
      if ((wr_en && data_full) || commit_err)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (data_push)
      data_mem[data_wr_ptr[DAW-1:0]] <= wr_data;
    if (commit_ok)
      len_mem[len_wr_ptr[LAW-1:0]] <= commit_len;
  end

  // Sequencer. Timers count down to zero; each state's exit edge is part of
  // its interval, so SETUP loads CS_SETUP-2 to leave room for the LOAD edge
  // and the first shift_en lands exactly CS_SETUP cycles after cs_n falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cs_n        <= 1'b1;
      shift_en    <= 1'b0;
      shift_data  <= '0;
      remaining   <= '0;
      timer       <= '0;
      data_rd_ptr <= '0;
      len_rd_ptr  <= '0;
    end else begin
      shift_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!len_empty) begin
            remaining  <= len_mem[len_rd_ptr[LAW-1:0]];
            len_rd_ptr <= len_rd_ptr + lptr_t'(1);
            cs_n       <= 1'b0;
            timer      <= tmr_t'(CS_SETUP - 2);
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (timer == '0)
            state <= LOAD;
          else
            timer <= timer - tmr_t'(1);
        end
        LOAD: begin
          shift_data  <= data_mem[data_rd_ptr[DAW-1:0]];
          data_rd_ptr <= data_rd_ptr + len_t'(1);
          shift_en    <= 1'b1;
          remaining   <= remaining - len_t'(1);
          state       <= WAIT;
        end
        WAIT: begin
          if (shift_done) begin
            if (remaining != '0) begin
              state <= LOAD;
            end else begin
              timer <= tmr_t'(CS_HOLD - 1);
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (timer == '0) begin
            cs_n  <= 1'b1;
            timer <= tmr_t'(CS_GAP - 1);
            state <= GAP;
          end else begin
            timer <= timer - tmr_t'(1);
          end
        end
        GAP: begin
          if (timer == '0)
            state <= IDLE;
          else
            timer <= timer - tmr_t'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frontpanel_spi_sequencer.sv
// tb_frontpanel_spi_sequencer
// Directed bench for frontpanel_spi_sequencer. Expected bytes and frame
// lengths are queued when a commit is accepted by the bench's own model and
// are consumed by an SPI host model that also answers shift_en with
// shift_done and times the cs_n framing.
module tb_frontpanel_spi_sequencer;

  localparam int DD = 64;
  localparam int LD = 4;
  localparam int SU = 16;
  localparam int HO = 16;
  localparam int GP = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       commit = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       shift_done = 1'b0;
  logic       shift_en, cs_n, busy, overflow;
  logic [7:0] shift_data;
  logic [6:0] data_free;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_bytes[$];
  int         exp_frames[$];
  logic [7:0] pend[$];

  // Host model controls (written by the main sequence only).
  bit host_auto  = 1'b1;
  int host_delay = 40;
  int kick_req   = 0;

  // Host model state (written by the host block only).
  int cyc = 0;
  int cd = 0;
  int kick_seen = 0;
  int fall_cyc = 0, rise_cyc = 0, done_cyc = 0;
  int nbytes = 0, bytes_seen = 0, frames_started = 0;
  bit have_rise = 1'b0;
  bit prev_cs = 1'b1;

  frontpanel_spi_sequencer #(
    .DATA_DEPTH(DD), .LEN_DEPTH(LD), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .commit(commit),
    .overflow_clr(overflow_clr), .shift_en(shift_en), .shift_data(shift_data),
    .shift_done(shift_done), .cs_n(cs_n), .busy(busy), .data_free(data_free),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI host model and frame monitor, sampled on the falling edge.
  always @(negedge clk) begin
    shift_done = 1'b0;
    if (rst) begin
      cd        = 0;
      have_rise = 1'b0;
      prev_cs   = 1'b1;
      kick_seen = kick_req;
    end else begin
      if (prev_cs && !cs_n) begin
        if (have_rise) chk("cs_gap_ge_33", 32'((cyc - rise_cyc) >= GP + 1), 1);
        fall_cyc = cyc;
        nbytes = 0;
        frames_started++;
      end
      if (!prev_cs && cs_n) begin
        chk("cs_hold", cyc - done_cyc, HO);
        chk("frame_queued", 32'(exp_frames.size() != 0), 1);
        if (exp_frames.size() != 0) chk("frame_len", nbytes, exp_frames.pop_front());
        rise_cyc = cyc;
        have_rise = 1'b1;
      end
      prev_cs = cs_n;
      if (shift_en) begin
        chk("shift_under_cs", 32'(cs_n), 0);
        if (nbytes == 0) chk("cs_setup", cyc - fall_cyc, SU);
        chk("byte_queued", 32'(exp_bytes.size() != 0), 1);
        if (exp_bytes.size() != 0) chk("shift_data", 32'(shift_data), 32'(exp_bytes.pop_front()));
        nbytes++;
        bytes_seen++;
        if (host_auto) cd = host_delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          shift_done = 1'b1;
          done_cyc = cyc + 1;
        end
      end
      if (kick_seen != kick_req) begin
        kick_seen = kick_req;
        shift_done = 1'b1;
        done_cyc = cyc + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit keep);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (keep) pend.push_back(b);
  endtask

  task automatic close_frame();
    exp_frames.push_back(pend.size());
    foreach (pend[i]) exp_bytes.push_back(pend[i]);
    pend.delete();
  endtask

  task automatic do_commit(input bit accepted);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    if (accepted) close_frame();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || cs_n !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic wait_bytes(input string tag, input int target, input int budget);
    int n = 0;
    while (bytes_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bytes_seen >= target), 1);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames_started < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(frames_started >= target), 1);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: observed no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin : main
    int f0, b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_shift_en", 32'(shift_en), 0);
    chk("rst_shift_data", 32'(shift_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data_free", 32'(data_free), DD);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three-byte frame, host answers 40 cycles after each shift_en
    host_delay = 40;
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    push(8'h43, 1'b1);
    chk("free_after_3", 32'(data_free), DD - 3);
    do_commit(1'b1);
    chk("cs_high_after_commit", 32'(cs_n), 1);
    chk("busy_after_commit", 32'(busy), 1);
    @(negedge clk);
    chk("cs_low_next", 32'(cs_n), 0);
    wait_idle("t1_idle", 1000);
    chk("free_after_t1", 32'(data_free), DD);

    // Back-to-back frames of 2 and 1 bytes
    host_delay = 10;
    push(8'h10, 1'b1);
    push(8'h11, 1'b1);
    do_commit(1'b1);
    push(8'h12, 1'b1);
    do_commit(1'b1);
    wait_idle("t2_idle", 1000);

    // Commit with nothing pending
    f0 = frames_started;
    do_commit(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("empty_commit_busy", 32'(busy), 0);
      chk("empty_commit_cs", 32'(cs_n), 1);
      @(negedge clk);
    end
    chk("empty_commit_frames", frames_started, f0);

    // Byte written in the commit cycle joins the frame
    push(8'h54, 1'b1);
    wr_en = 1'b1;
    wr_data = 8'h55;
    pend.push_back(8'h55);
    do_commit(1'b1);
    wr_en = 1'b0;
    wait_idle("same_cycle_idle", 1000);

    // Byte FIFO overflow: 65 writes, 64 kept
    host_delay = 4;
    for (int i = 0; i < DD; i++) push(8'(i + 8'h80), 1'b1);
    push(8'hFF, 1'b0);
    chk("full_data_free", 32'(data_free), 0);
    chk("full_overflow", 32'(overflow), 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("overflow_cleared", 32'(overflow), 0);
    overflow_clr = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    overflow_clr = 1'b0;
    wr_en = 1'b0;
    chk("overflow_set_wins", 32'(overflow), 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("overflow_cleared2", 32'(overflow), 0);
    do_commit(1'b1);
    wait_idle("full_idle", 3000);
    chk("full_free_restored", 32'(data_free), DD);

    // Length FIFO overflow while the first frame is stalled
    host_auto = 1'b0;
    f0 = frames_started;
    b0 = bytes_seen;
    push(8'hA0, 1'b1);
    do_commit(1'b1);
    wait_bytes("stall_first_byte", b0 + 1, 100);
    for (int i = 1; i <= LD; i++) begin
      push(8'(8'hB0 + i), 1'b1);
      do_commit(1'b1);
    end
    push(8'hB5, 1'b1);
    do_commit(1'b0);
    chk("len_overflow", 32'(overflow), 1);
    chk("stall_busy", 32'(busy), 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("len_overflow_cleared", 32'(overflow), 0);
    host_auto = 1'b1;
    kick_req++;
    wait_frames("stall_next_frame", f0 + 2, 500);
    push(8'hB6, 1'b1);
    do_commit(1'b1);
    wait_idle("stall_idle", 3000);
    chk("stall_overflow_quiet", 32'(overflow), 0);

    // Reset during WAIT
    host_auto = 1'b0;
    b0 = bytes_seen;
    push(8'h60, 1'b1);
    push(8'h61, 1'b1);
    do_commit(1'b1);
    wait_bytes("rst_test_byte", b0 + 1, 100);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cs_n", 32'(cs_n), 1);
    chk("async_rst_shift_en", 32'(shift_en), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_free", 32'(data_free), DD);
    exp_bytes.delete();
    exp_frames.delete();
    pend.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b0 = bytes_seen;
    kick_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done_cs", 32'(cs_n), 1);
      chk("post_rst_done_busy", 32'(busy), 0);
    end
    chk("post_rst_no_shift", bytes_seen, b0);
    host_auto = 1'b1;
    push(8'h70, 1'b1);
    do_commit(1'b1);
    wait_idle("post_rst_idle", 1000);
    chk("post_rst_bytes", bytes_seen, b0 + 1);

    chk("bytes_left", exp_bytes.size(), 0);
    chk("frames_left", exp_frames.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
